// File: rtl/gpio_serial_loader.sv
// Loads one configuration word per digital GPIO pad from the register file and
// shifts the words, highest pad first, into the daisy-chained pad control blocks.
module gpio_serial_loader #(
  parameter int NPADS    = 27,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 2,
  parameter int AW       = 5
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                xfer_start,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       cfg_addr,
  output logic                cfg_rd,
  input  logic [CFG_BITS-1:0] cfg_rdata,
  output logic                serial_clock,
  output logic                serial_data,
  output logic                serial_load,
  output logic                serial_resetn
);

  // state   | meaning
  // IDLE    | waiting for xfer_start
  // FETCH   | read strobe for pad p
  // CAPTURE | register file word lands in the shift register
  // SHIFT   | clock the word out, MSB first
  // LOAD    | latch strobe, then hold time
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SHIFT, LOAD} state_t;

  localparam int PW = (NPADS > 1) ? $clog2(NPADS) : 1;
  localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int CW = $clog2(2 * CLK_DIV);

  localparam logic [PW-1:0] P_LAST = PW'(NPADS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(CFG_BITS - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLK_DIV);
  localparam logic [CW-1:0] C_LAST = CW'(2 * CLK_DIV - 1);

  state_t              state, state_n;
  logic [PW-1:0]       p, p_n;
  logic [BW-1:0]       b, b_n;
  logic [CW-1:0]       c, c_n;
  logic [CFG_BITS-1:0] sr, sr_n;

  always_comb begin
    state_n = state;
    p_n     = p;
    b_n     = b;
    c_n     = c;
    sr_n    = sr;
    unique case (state)
      IDLE: begin
        if (xfer_start) begin
          state_n = FETCH;
          p_n     = P_LAST;
          c_n     = '0;
        end
      end
      FETCH: state_n = CAPTURE;
      CAPTURE: begin
        sr_n    = cfg_rdata;
        b_n     = B_LAST;
        c_n     = '0;
        state_n = SHIFT;
      end
      SHIFT: begin
        if (c == C_LAST) begin
          c_n  = '0;
          sr_n = sr << 1;
          if (b != '0) begin
            b_n = b - 1'b1;
          end else if (p != '0) begin
            p_n     = p - 1'b1;
            state_n = FETCH;
          end else begin
            state_n = LOAD;
          end
        end else begin
          c_n = c + 1'b1;
        end
      end
      LOAD: begin
        if (c == C_LAST) begin
          c_n = '0;
          // done shares this cycle with busy, so a start here chains seamlessly
          if (xfer_start) begin
            state_n = FETCH;
            p_n     = P_LAST;
          end else begin
            state_n = IDLE;
          end
        end else begin
          c_n = c + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so the chain sees glitch-free lines.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      p             <= '0;
      b             <= '0;
      c             <= '0;
      sr            <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_rd        <= 1'b0;
      serial_clock  <= 1'b0;
      serial_data   <= 1'b0;
      serial_load   <= 1'b0;
      serial_resetn <= 1'b0;
    end else begin
      state         <= state_n;
      p             <= p_n;
      b             <= b_n;
      c             <= c_n;
      sr            <= sr_n;
      busy          <= (state_n != IDLE);
      done          <= (state_n == LOAD) && (c_n == C_LAST);
      cfg_rd        <= (state_n == FETCH);
      serial_clock  <= (state_n == SHIFT) && (c_n >= C_HALF);
      serial_data   <= (state_n == SHIFT) && sr_n[CFG_BITS-1];
      serial_load   <= (state_n == LOAD) && (c_n < C_HALF);
      serial_resetn <= 1'b1;
    end
  end

  assign cfg_addr = AW'(p);

endmodule
